// File: rtl/reg_bank_param_pkg.sv
// Shared opcode encodings for the parametrised instruction-driven register bank.
package reg_bank_param_pkg;

  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OpNop = 4'd0;
  localparam logic [OPW-1:0] OpLdi = 4'd1;
  localparam logic [OPW-1:0] OpRdo = 4'd2;
  localparam logic [OPW-1:0] OpMov = 4'd3;
  localparam logic [OPW-1:0] OpInc = 4'd4;
  localparam logic [OPW-1:0] OpDec = 4'd5;
  localparam logic [OPW-1:0] OpClr = 4'd6;

endpackage

// File: rtl/reg_bank_param_alu.sv
// Next-value computation for the selected register; pure combinational.
module reg_bank_param_alu
  import reg_bank_param_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic [OPW-1:0]   op_i,
  input  logic [Width-1:0] cur_i,
  input  logic [Width-1:0] imm_i,
  input  logic [Width-1:0] src_i,
  output logic [Width-1:0] nxt_o
);

  always_comb begin
    nxt_o = cur_i;
    case (op_i)
      OpLdi:   nxt_o = imm_i;
      OpMov:   nxt_o = src_i;
      OpInc:   nxt_o = cur_i + Width'(1);
      OpDec:   nxt_o = cur_i - Width'(1);
      default: nxt_o = cur_i;
    endcase
  end

endmodule

// File: rtl/reg_bank_param.sv
// COUNT x WIDTH register bank executing one instruction per enabled clock,
// with registered read-out, a read-valid strobe and a sticky undefined-opcode flag.
module reg_bank_param
  import reg_bank_param_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COUNT = 8,
  localparam int unsigned SELW = $clog2(COUNT)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [OPW+SELW+WIDTH-1:0] inst,
  input  logic                      inst_en,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic                      error
);

  logic [WIDTH-1:0] regs_q [COUNT];
  logic [WIDTH-1:0] regs_d [COUNT];
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             error_q, error_d;

  // Gate the word so an undriven inst cannot reach the decode while disabled.
  logic [OPW+SELW+WIDTH-1:0] inst_g;
  logic [OPW-1:0]            op;
  logic [SELW-1:0]           sel;
  logic [WIDTH-1:0]          imm;
  logic [SELW-1:0]           src_sel;
  logic [WIDTH-1:0]          alu_nxt;

  assign inst_g  = inst_en ? inst : '0;
  assign op      = inst_g[OPW+SELW+WIDTH-1 -: OPW];
  assign sel     = inst_g[SELW+WIDTH-1 -: SELW];
  assign imm     = inst_g[WIDTH-1:0];
  assign src_sel = imm[SELW-1:0];

  reg_bank_param_alu #(
    .Width(WIDTH)
  ) u_alu (
    .op_i (op),
    .cur_i(regs_q[sel]),
    .imm_i(imm),
    .src_i(regs_q[src_sel]),
    .nxt_o(alu_nxt)
  );

  always_comb begin
    regs_d      = regs_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    error_d     = error_q;
    case (op)
      OpNop: ;
      OpLdi, OpMov, OpInc, OpDec: regs_d[sel] = alu_nxt;
      OpRdo: begin
        out_d       = regs_q[sel];
        out_valid_d = 1'b1;
      end
      OpClr: begin
        for (int i = 0; i < COUNT; i++) regs_d[i] = '0;
      end
      default: error_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < COUNT; i++) regs_q[i] <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      error_q     <= error_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign error     = error_q;

endmodule

// File: tb/tb_reg_bank_param.sv
// Directed bench for reg_bank_param (WIDTH=8, COUNT=8): per-cycle model compare
// plus literal spot checks.
module tb_reg_bank_param;

  logic        clock;
  logic        reset;
  logic [14:0] inst;
  logic        inst_en;
  logic [7:0]  out;
  logic        out_valid;
  logic        error;

  int n_vec = 0;
  int n_err = 0;

  reg_bank_param #(
    .WIDTH(8),
    .COUNT(8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .inst     (inst),
    .inst_en  (inst_en),
    .out      (out),
    .out_valid(out_valid),
    .error    (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: architectural state updated from the rules, one instruction per edge.
  logic [7:0] m_regs [8];
  logic [7:0] m_out;
  logic       m_valid;
  logic       m_err;
  logic       started = 1'b0;

  always @(posedge clock) begin
    logic [3:0] op;
    logic [2:0] s;
    logic [7:0] im;
    if (!reset) begin
      foreach (m_regs[i]) m_regs[i] = 8'h00;
      m_out   = 8'h00;
      m_valid = 1'b0;
      m_err   = 1'b0;
      started = 1'b1;
    end else begin
      m_valid = 1'b0;
      if (inst_en) begin
        op = inst[14:11];
        s  = inst[10:8];
        im = inst[7:0];
        if (op == 4'd1) m_regs[s] = im;
        else if (op == 4'd2) begin
          m_out   = m_regs[s];
          m_valid = 1'b1;
        end
        else if (op == 4'd3) m_regs[s] = m_regs[im[2:0]];
        else if (op == 4'd4) m_regs[s] = m_regs[s] + 8'd1;
        else if (op == 4'd5) m_regs[s] = m_regs[s] - 8'd1;
        else if (op == 4'd6) foreach (m_regs[i]) m_regs[i] = 8'h00;
        else if (op != 4'd0) m_err = 1'b1;
      end
    end
  end

  // Per-cycle compare of DUT outputs against the model, away from the active edge.
  always @(negedge clock) begin
    if (started) begin
      n_vec++;
      if (out !== m_out || out_valid !== m_valid || error !== m_err) begin
        n_err++;
        $display("FAIL model t=%0t out=%h/%h valid=%b/%b error=%b/%b (got/exp)",
                 $time, out, m_out, out_valid, m_valid, error, m_err);
      end
    end
  end

  function automatic logic [14:0] mk(input logic [3:0] op, input logic [2:0] s,
                                     input logic [7:0] im);
    return {op, s, im};
  endfunction

  task automatic step(input logic en, input logic [14:0] w);
    inst_en = en;
    inst    = w;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  logic [7:0] vals [8] = '{8'hAE, 8'hAB, 8'hEF, 8'h2F, 8'h72, 8'h3E, 8'h92, 8'h61};

  initial begin
    reset   = 1'b0;
    inst_en = 1'b0;
    inst    = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_out", out, 8'h00);
    chk("reset_valid", {7'd0, out_valid}, 8'h00);
    chk("reset_error", {7'd0, error}, 8'h00);
    reset = 1'b1;

    // 1: load each register and read it back
    for (int i = 0; i < 8; i++) begin
      step(1'b1, mk(4'd1, 3'(i), vals[i]));
      step(1'b1, mk(4'd2, 3'(i), 8'h00));
      chk("ldi_rdo", out, vals[i]);
      chk("ldi_rdo_valid", {7'd0, out_valid}, 8'h01);
    end
    step(1'b1, mk(4'd0, 3'd0, 8'h00));
    chk("valid_drop", {7'd0, out_valid}, 8'h00);

    // 2: wrap-around
    step(1'b1, mk(4'd1, 3'd3, 8'hFF));
    step(1'b1, mk(4'd4, 3'd3, 8'h00));
    step(1'b1, mk(4'd2, 3'd3, 8'h00));
    chk("inc_wrap", out, 8'h00);
    step(1'b1, mk(4'd5, 3'd3, 8'h00));
    step(1'b1, mk(4'd2, 3'd3, 8'h00));
    chk("dec_wrap", out, 8'hFF);
    step(1'b1, mk(4'd1, 3'd1, 8'h7F));
    step(1'b1, mk(4'd4, 3'd1, 8'h00));
    step(1'b1, mk(4'd2, 3'd1, 8'h00));
    chk("inc_7f", out, 8'h80);

    // 3: move, self-move, clear-all; back-to-back RDO
    step(1'b1, mk(4'd1, 3'd2, 8'h5A));
    step(1'b1, mk(4'd3, 3'd6, 8'hF2));
    step(1'b1, mk(4'd2, 3'd6, 8'h00));
    chk("mov", out, 8'h5A);
    step(1'b1, mk(4'd3, 3'd6, 8'h06));
    step(1'b1, mk(4'd2, 3'd6, 8'h00));
    chk("mov_self", out, 8'h5A);
    step(1'b1, mk(4'd2, 3'd0, 8'h00));
    chk("rdo_b2b", out, 8'hAE);
    chk("rdo_b2b_valid", {7'd0, out_valid}, 8'h01);
    step(1'b1, mk(4'd6, 3'd5, 8'hFF));
    chk("clr_out_hold", out, 8'hAE);
    step(1'b1, mk(4'd2, 3'd6, 8'h00));
    chk("clr", out, 8'h00);
    chk("clr_error", {7'd0, error}, 8'h00);

    // 4: disabled instructions
    step(1'b1, mk(4'd1, 3'd1, 8'h44));
    step(1'b0, mk(4'd1, 3'd1, 8'h87));
    step(1'b1, mk(4'd2, 3'd1, 8'h00));
    chk("disabled_ldi", out, 8'h44);
    step(1'b0, 15'bx);
    chk("x_valid", {7'd0, out_valid}, 8'h00);
    chk("x_out", out, 8'h44);
    chk("x_error", {7'd0, error}, 8'h00);

    // 5: undefined opcode
    step(1'b1, mk(4'hF, 3'd1, 8'hAB));
    chk("undef_error", {7'd0, error}, 8'h01);
    step(1'b1, mk(4'd2, 3'd1, 8'h00));
    chk("undef_noreg", out, 8'h44);
    step(1'b1, mk(4'd1, 3'd1, 8'h27));
    step(1'b1, mk(4'd2, 3'd1, 8'h00));
    chk("after_undef", out, 8'h27);
    chk("error_sticky", {7'd0, error}, 8'h01);

    // 6: mid-stream reset; LDI on the reset edge is discarded
    reset = 1'b0;
    step(1'b1, mk(4'd1, 3'd2, 8'h55));
    step(1'b1, mk(4'd0, 3'd0, 8'h00));
    reset = 1'b1;
    chk("rst_out", out, 8'h00);
    chk("rst_error", {7'd0, error}, 8'h00);
    chk("rst_valid", {7'd0, out_valid}, 8'h00);
    step(1'b1, mk(4'd2, 3'd2, 8'h00));
    chk("rst_discard", out, 8'h00);
    step(1'b1, mk(4'd2, 3'd1, 8'h00));
    chk("rst_regs", out, 8'h00);
    step(1'b1, mk(4'd1, 3'd0, 8'h1A));
    step(1'b1, mk(4'd2, 3'd0, 8'h00));
    chk("post_rst", out, 8'h1A);
    step(1'b0, 15'd0);
    step(1'b0, 15'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bank_param.md
Name: reg_bank_param

Overview:
Parametrised successor to the 8x8 instruction-driven register bank. It holds COUNT registers of WIDTH bits and executes one instruction per enabled clock: load-immediate, read-out, register-to-register move, increment, decrement and clear-all. It adds a sticky error flag for undefined opcodes and a one-cycle read-valid strobe. It sits under a controller that issues instruction words with an enable.

Parameters:
WIDTH, 8, data width of each register and of out.
COUNT, 8, number of registers; power of two, 2..16.
SELW, log2(COUNT), derived (localparam), register-select width.

Ports:
clock  in  1  single system clock, rising edge.
reset  in  1  synchronous, active-low; sampled on rising clock edge.
inst  in  4+SELW+WIDTH  instruction word {op[3:0], sel[SELW-1:0], imm[WIDTH-1:0]}.
inst_en  in  1  instruction valid; inst is ignored when 0.
out  out  WIDTH  last value read by RDO (registered).
out_valid  out  1  high for exactly one cycle after an executed RDO.
error  out  1  sticky; set by an enabled undefined opcode.

Behaviour:
- Reset (reset==0 at a rising edge): all registers = 0, out = 0, out_valid = 0, error = 0. Reset overrides inst_en. Reset mid-sequence discards the instruction presented in that cycle.
- Every instruction takes effect at the rising edge on which inst_en==1. Results are visible the following cycle. There are no stalls or back-pressure, and no busy state.
- Opcodes (op): NOP=0, LDI=1, RDO=2, MOV=3, INC=4, DEC=5, CLR=6. Values 7..15 are undefined.
- LDI: reg[sel] <= imm.
- RDO: out <= reg[sel]; out_valid <= 1 in the next cycle only.
- MOV: reg[sel] <= reg[imm[SELW-1:0]]. Upper imm bits are ignored. When source equals destination, the register is unchanged.
- INC/DEC: reg[sel] <= reg[sel] +/- 1, modulo 2^WIDTH. All-ones+1 wraps to 0; 0-1 wraps to all-ones. No carry flag.
- CLR: all registers <= 0 in one cycle. sel and imm are ignored. out and error are unchanged.
- Undefined opcode: no register or out change; error <= 1. error stays set until reset.
- inst_en==0: nothing changes; out holds; out_valid <= 0. X on inst while inst_en==0 must not propagate.
- out changes only on RDO. A later write to the register last read does not update out.
- out_valid <= 0 on every cycle that does not execute an RDO, including NOP, undefined opcodes and disabled cycles.
- Back-to-back RDO: out updates and out_valid stays high on each consecutive cycle.
- Write then RDO of the same register on the next cycle returns the new value (no forwarding hazard).

Decomposition:
- Shared package reg_bank_param_pkg holds the opcode localparams (NOP..CLR) and OPW=4.
- One combinational sub-module, reg_bank_param_alu, computes the next value for the selected register from op, current value, imm and the move source.
- The top level holds the register array, decode, out/out_valid/error flops and reset.

Test Plan:
All scenarios use WIDTH=8, COUNT=8 (inst 15 bits).
1. LDI sel=0..7 with AE,AB,EF,2F,72,3E,92,61, each followed by RDO of the same sel -> out shows each value the cycle after the RDO, with out_valid high for one cycle.
2. LDI r3=FF; INC r3; RDO r3 -> out=00. Then DEC r3; RDO r3 -> out=FF. Also LDI r1=7F; INC; RDO -> out=80.
3. LDI r2=5A; MOV sel=6, imm=02; RDO r6 -> out=5A. MOV r6<-r6 leaves r6=5A. CLR; RDO r6 -> out=00, and error is unchanged.
4. LDI r1=87 with inst_en=0 -> RDO r1 returns the prior value. Inst=X while disabled -> out/error hold, out_valid=0.
5. Enabled op=F, imm=AB -> error=1 the next cycle, no register changes. A following LDI r1=27 executes, and error stays 1.
6. reset=0 for 2 cycles mid-stream -> all registers, out, out_valid and error read 0. LDI r0=1A then RDO r0 -> out=1A. LDI asserted on the same edge as reset=0 is discarded.
